// File: rtl/txpause_gate.sv
// TX-path AXI-Stream gate that holds off new frames while the link partner is paused.
// Frames already in flight complete; pause entries and paused cycles are counted.
module txpause_gate #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              cfg_tx_pause_enable,
    input  logic              cfg_stats_clear,
    input  logic              rx_pause_active,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    input  logic [0:0]        s_tuser,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic [0:0]        m_tuser,
    input  logic              m_tready,
    output logic              tx_paused,
    output logic [15:0]       pause_event_count,
    output logic [31:0]       paused_cycle_count
);

    typedef enum logic [1:0] {
        s_idle,
        s_frame,
        s_paused
    } state_t;

    state_t state, next_state;
    logic   pause_req;
    logic   gate_open;
    logic   load;
    logic   enter_pause;

    assign pause_req = rx_pause_active & cfg_tx_pause_enable;

    // aresetn also gates ready so nothing is accepted while the block is held in reset.
    assign s_tready    = aresetn & gate_open & (~m_tvalid | m_tready);
    assign load        = s_tvalid & s_tready;
    assign enter_pause = (next_state == s_paused) && (state != s_paused);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        next_state = state;
        gate_open  = 1'b0;
        unique case (state)
            s_idle: begin
                gate_open = ~pause_req;
                if (pause_req) begin
                    next_state = s_paused;
                end else if (load && !s_tlast) begin
                    next_state = s_frame;
                end
            end
            s_frame: begin
                gate_open = 1'b1;
                if (load && s_tlast) begin
                    next_state = pause_req ? s_paused : s_idle;
                end
            end
            s_paused: begin
                if (!pause_req) begin
                    next_state = s_idle;
                end
            end
            default: next_state = s_idle;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= s_idle;
            tx_paused <= 1'b0;
        end else begin
            state     <= next_state;
            tx_paused <= (next_state == s_paused);
        end
    end

    // Single register slice; a held beat keeps draining even while paused.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: datapath registers are reset too, so the output bus reads zero out of reset.
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= '0;
        end else if (load) begin
            m_tdata  <= s_tdata;
            m_tkeep  <= s_tkeep;
            m_tvalid <= 1'b1;
            m_tlast  <= s_tlast;
            m_tuser  <= s_tuser;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    // Saturating statistics; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            pause_event_count  <= '0;
            paused_cycle_count <= '0;
        end else if (cfg_stats_clear) begin
            pause_event_count  <= '0;
            paused_cycle_count <= '0;
        end else begin
            if (enter_pause && !(&pause_event_count)) begin
                pause_event_count <= pause_event_count + 16'd1;
            end
            if ((state == s_paused) && !(&paused_cycle_count)) begin
                paused_cycle_count <= paused_cycle_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_txpause_gate.sv
// Directed bench for txpause_gate: hand-computed pause timing and counter values,
// plus a queue scoreboard watching the AXIS stream for loss, duplication or reordering.
module tb_txpause_gate;

    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int WAIT_MAX = 2000;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic              cfg_tx_pause_enable = 1'b1;
    logic              cfg_stats_clear = 1'b0;
    logic              rx_pause_active = 1'b0;
    logic [DATA_W-1:0] s_tdata = '0;
    logic [KEEP_W-1:0] s_tkeep = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tlast = 1'b0;
    logic [0:0]        s_tuser = '0;
    logic              s_tready;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tvalid;
    logic              m_tlast;
    logic [0:0]        m_tuser;
    logic              m_tready = 1'b1;
    logic              tx_paused;
    logic [15:0]       pause_event_count;
    logic [31:0]       paused_cycle_count;

    int total = 0;
    int bad   = 0;

    logic [73:0] sb_q[$];
    logic        sb_on = 1'b0;
    logic        hold_pending = 1'b0;
    logic [74:0] hold_val = '0;
    logic        rand_done;

    txpause_gate #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
        .clk                (clk),
        .aresetn            (aresetn),
        .cfg_tx_pause_enable(cfg_tx_pause_enable),
        .cfg_stats_clear    (cfg_stats_clear),
        .rx_pause_active    (rx_pause_active),
        .s_tdata            (s_tdata),
        .s_tkeep            (s_tkeep),
        .s_tvalid           (s_tvalid),
        .s_tlast            (s_tlast),
        .s_tuser            (s_tuser),
        .s_tready           (s_tready),
        .m_tdata            (m_tdata),
        .m_tkeep            (m_tkeep),
        .m_tvalid           (m_tvalid),
        .m_tlast            (m_tlast),
        .m_tuser            (m_tuser),
        .m_tready           (m_tready),
        .tx_paused          (tx_paused),
        .pause_event_count  (pause_event_count),
        .paused_cycle_count (paused_cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [63:0] d, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = d[7:0] | 8'h01;
        s_tlast  = last;
        s_tuser  = d[1];
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last);
        int n;
        n = 0;
        set_beat(d, last);
        @(negedge clk);
        while (!s_tready && n < WAIT_MAX) begin
            n++;
            @(negedge clk);
        end
        if (n >= WAIT_MAX) check("send_timeout", 96'(n), 96'(0));
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        m_tready = 1'b1;
        s_tvalid = 1'b0;
        repeat (4) tick();
        check("sb_empty", 96'(sb_q.size()), 96'(0));
    endtask

    // Scoreboard and AXIS hold-stability monitor.
    always @(negedge clk) begin
        logic [73:0] exp_beat;
        if (sb_on) begin
            if (hold_pending) check("axis_hold", {m_tvalid, m_tuser, m_tlast, m_tkeep, m_tdata}, hold_val);
            if (m_tvalid && m_tready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 96'(1), 96'(0));
                end else begin
                    exp_beat = sb_q.pop_front();
                    check("sb_beat", {m_tuser, m_tlast, m_tkeep, m_tdata}, exp_beat);
                end
            end
            if (s_tvalid && s_tready) sb_q.push_back({s_tuser, s_tlast, s_tkeep, s_tdata});
            hold_pending = m_tvalid && !m_tready;
            hold_val     = {m_tvalid, m_tuser, m_tlast, m_tkeep, m_tdata};
        end else begin
            hold_pending = 1'b0;
        end
    end

    initial begin
        int stalls;
        int lat_err;
        int err;
        logic [63:0] d;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 96'(s_tready), 96'(0));
        check("rst_m_tvalid", 96'(m_tvalid), 96'(0));
        aresetn = 1'b1;
        tick();
        check("idle_tx_paused", 96'(tx_paused), 96'(0));
        check("idle_s_tready", 96'(s_tready), 96'(1));
        sb_on = 1'b1;

        // Baseline: two 64-beat frames back to back, no bubbles, 1-cycle latency.
        stalls = 0;
        lat_err = 0;
        for (int i = 0; i < 128; i++) begin
            d = 64'hA000_0000_0000_0000 | 64'(i);
            set_beat(d, (i % 64) == 63);
            #1;
            if (!s_tready) stalls++;
            tick();
            if (!(m_tvalid && m_tdata == d)) lat_err++;
        end
        s_tvalid = 1'b0;
        check("base_stalls", 96'(stalls), 96'(0));
        check("base_latency", 96'(lat_err), 96'(0));
        drain();
        check("base_events", 96'(pause_event_count), 96'(0));

        // Mid-frame pause: raised at beat 3 of a 10-beat frame and held for 100 cycles.
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) rx_pause_active = 1'b1;
            set_beat(64'hB000 + 64'(i), i == 9);
            #1;
            if (!s_tready) stalls++;
            tick();
        end
        check("mid_frame_stalls", 96'(stalls), 96'(0));
        check("mid_tx_paused", 96'(tx_paused), 96'(1));
        // Pause was raised 7 cycles ago; 93 more cycles complete its 100-cycle hold.
        set_beat(64'hC000, 1'b0);
        err = 0;
        for (int k = 0; k < 93; k++) begin
            #1;
            if (s_tready) err++;
            tick();
        end
        rx_pause_active = 1'b0;
        #1;
        check("mid_held", 96'(err + int'(s_tready)), 96'(0));
        tick();
        check("mid_release_tx_paused", 96'(tx_paused), 96'(0));
        check("mid_release_s_tready", 96'(s_tready), 96'(1));
        // Paused from the cycle after tlast (7 cycles after pause rose) through the drop cycle.
        check("mid_event_count", 96'(pause_event_count), 96'(1));
        check("mid_cycle_count", 96'(paused_cycle_count), 96'(94));
        tick();
        for (int i = 1; i < 4; i++) send_beat(64'hC000 + 64'(i), i == 3);
        drain();

        // Pause at frame boundary: blocks the same cycle, 20 paused cycles.
        cfg_stats_clear = 1'b1;
        tick();
        cfg_stats_clear = 1'b0;
        set_beat(64'hD000, 1'b1);
        rx_pause_active = 1'b1;
        #1;
        check("bnd_block_same_cycle", 96'(s_tready), 96'(0));
        err = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_tready) err++;
        end
        rx_pause_active = 1'b0;
        #1;
        check("bnd_held", 96'(err + int'(s_tready)), 96'(0));
        tick();
        check("bnd_accept_next", 96'(s_tready), 96'(1));
        check("bnd_cycle_count", 96'(paused_cycle_count), 96'(20));
        check("bnd_event_count", 96'(pause_event_count), 96'(1));
        tick();
        s_tvalid = 1'b0;
        drain();

        // Pause disabled: traffic unaffected.
        cfg_tx_pause_enable = 1'b0;
        rx_pause_active = 1'b1;
        stalls = 0;
        err = 0;
        for (int i = 0; i < 4; i++) begin
            set_beat(64'hE000 + 64'(i), i == 3);
            #1;
            if (!s_tready) stalls++;
            tick();
            if (tx_paused) err++;
        end
        s_tvalid = 1'b0;
        check("dis_stalls", 96'(stalls), 96'(0));
        check("dis_tx_paused", 96'(err), 96'(0));
        // Enable toggled 1->0 while paused exits on the next cycle.
        cfg_tx_pause_enable = 1'b1;
        tick();
        check("dis_entered", 96'(tx_paused), 96'(1));
        cfg_tx_pause_enable = 1'b0;
        #1;
        check("dis_still_blocked", 96'(s_tready), 96'(0));
        tick();
        check("dis_exit_tx_paused", 96'(tx_paused), 96'(0));
        check("dis_exit_s_tready", 96'(s_tready), 96'(1));
        rx_pause_active = 1'b0;
        cfg_tx_pause_enable = 1'b1;
        drain();

        // Random backpressure with pause pulses; the scoreboard checks ordering.
        rand_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 8; f++) begin
                    int len;
                    len = int'($urandom_range(1, 9));
                    for (int i = 0; i < len; i++) send_beat({32'(f), 32'($urandom)}, i == len - 1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    tick();
                    m_tready = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) rx_pause_active = ~rx_pause_active;
                end
            end
        join
        rx_pause_active = 1'b0;
        drain();

        // Reset mid-frame: everything clears at once.
        sb_on = 1'b0;
        m_tready = 1'b0;
        set_beat(64'hF0F0_0000_0000_0001, 1'b0);
        tick();
        set_beat(64'hF0F0_0000_0000_0002, 1'b0);
        tick();
        aresetn = 1'b0;
        #1;
        check("rst_mid_m_tvalid", 96'(m_tvalid), 96'(0));
        check("rst_mid_m_tdata", 96'(m_tdata), 96'(0));
        check("rst_mid_m_tkeep", 96'(m_tkeep), 96'(0));
        check("rst_mid_s_tready", 96'(s_tready), 96'(0));
        check("rst_mid_events", 96'(pause_event_count), 96'(0));
        check("rst_mid_cycles", 96'(paused_cycle_count), 96'(0));
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick();
        aresetn = 1'b1;
        sb_q.delete();
        tick();
        sb_on = 1'b1;

        // Saturation of the paused-cycle counter.
        @(negedge clk);
        force dut.paused_cycle_count = 32'hFFFF_FFFE;
        #1;
        release dut.paused_cycle_count;
        tick();
        rx_pause_active = 1'b1;
        repeat (5) tick();
        rx_pause_active = 1'b0;
        tick();
        check("sat_cycle_count", 96'(paused_cycle_count), 96'hFFFF_FFFF);
        tick();

        // Clear coincident with increments of both counters.
        rx_pause_active = 1'b1;
        cfg_stats_clear = 1'b1;
        tick();
        tick();
        check("clr_cycle_count", 96'(paused_cycle_count), 96'(0));
        check("clr_event_count", 96'(pause_event_count), 96'(0));
        cfg_stats_clear = 1'b0;
        tick();
        check("clr_then_count", 96'(paused_cycle_count), 96'(1));
        rx_pause_active = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
